inst_fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the MIPS datapath/controller pair.
- Owns the PC and issues word-aligned read requests to a variable-latency instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small prefetch queue and hands them to decode with a valid/ready handshake.
- Supports redirect (branch/jump/jal) with flush and discard of stale in-flight responses.

---
 rtl/inst_fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues imem reads, tags responses in order and
// buffers them for decode. Optional perf counters build with `FETCH_PERF_EN.
//
// Handshakes (request channel and decode channel): a transfer happens on a rising
// edge where valid && ready. valid never depends on ready, and a raised request
// holds its address until taken unless a redirect withdraws it.
module inst_fetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_drop_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);
  localparam logic [31:0]   PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;

  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [CW-1:0] q_count;

  logic [31:0]   t_pc [MAX_OUTST];
  logic [TW-1:0] t_rd;
  logic [TW-1:0] t_wr;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  logic [CW-1:0] outst_nxt;
  logic [CW-1:0] drop_nxt;

  function automatic logic [TW-1:0] t_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
  endfunction

  // Credit rule: queued plus in-flight words never exceed the queue size, so a
  // response always has a slot and the tag FIFO can never overflow.
  assign imem_req_valid = (state == ST_FETCH) & ~redirect
                        & (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C)
                        & (outstanding < MAX_C);
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = (q_count != '0);
  assign inst           = q_data[q_rd];
  assign inst_pc        = q_pc[q_rd];
  assign dbg_state      = state;

  always_comb begin
    req_fire  = imem_req_valid & imem_req_ready;
    rsp_keep  = imem_rsp_valid & ~redirect & (drop_cnt == '0);
    pop       = inst_valid & inst_ready & ~redirect;
    outst_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    // Everything still in flight after a redirect belongs to the old path.
    if (redirect) begin
      drop_nxt = outst_nxt;
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_nxt = drop_cnt - CW'(1);
    end else begin
      drop_nxt = drop_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC & PC_MASK;
      q_rd        <= '0;
      q_wr        <= '0;
      q_count     <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
      for (int i = 0; i < MAX_OUTST; i++) begin
        t_pc[i] <= '0;
      end
    end else begin
      outstanding <= outst_nxt;
      drop_cnt    <= drop_nxt;

      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH,
        ST_FLUSH: state <= (drop_nxt != '0) ? ST_FLUSH : ST_FETCH;
        default:  state <= ST_IDLE;
      endcase

      if (redirect) begin
        fetch_pc <= redirect_pc & PC_MASK;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (redirect) begin
        t_rd <= '0;
        t_wr <= '0;
      end else begin
        if (req_fire) begin
          t_pc[t_wr] <= fetch_pc;
          t_wr       <= t_inc(t_wr);
        end
        if (rsp_keep) begin
          t_rd <= t_inc(t_rd);
        end
      end

      if (redirect) begin
        q_rd    <= '0;
        q_wr    <= '0;
        q_count <= '0;
      end else begin
        if (rsp_keep) begin
          q_data[q_wr] <= imem_rsp_data;
          q_pc[q_wr]   <= t_pc[t_rd];
          q_wr         <= q_wr + AW'(1);
        end
        if (pop) begin
          q_rd <= q_rd + AW'(1);
        end
        q_count <= q_count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if ((state == ST_FETCH) && !inst_valid && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (imem_rsp_valid && !rsp_keep && (perf_drop_cnt != 16'hFFFF)) begin
        perf_drop_cnt <= perf_drop_cnt + 16'd1;
      end
    end
  end
`endif

  // A response with nothing in flight means the memory broke the protocol.
  assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: variable-latency memory model, fetch-stream model
// and directed scenarios (streaming, backpressure, redirect/flush, wrap, reset).
module tb_inst_fetch_unit;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect       = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  pend_t       pending[$];      // requests the memory still owes, in order
  logic [31:0] exp_q[$];        // current-path fetch addresses not yet consumed
  logic [31:0] accepted[$];     // every accepted request address this test
  logic [31:0] consumed[$];     // every inst_pc consumed this test
  int          consumed_cyc[$];
  int          avail;           // words delivered to the unit, not yet consumed
  int          epoch;
  int          dropped;
  logic [31:0] model_pc;
  logic        prev_stall;
  logic [31:0] prev_addr;

  int cyc       = 0;
  int lat       = 1;
  int acc_limit = 1000;
  int ready_mode = 0;
  logic hold    = 1'b0;
  int rel_cyc   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < accepted.size()) ? accepted[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] con_at(input int i);
    return (i < consumed.size()) ? consumed[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process (runs at each falling edge) ----------------
  task automatic monitor();
    logic acc;
    logic pop;
    int   stale;
    if (!rst) begin
      pending.delete();
      exp_q.delete();
      avail      = 0;
      model_pc   = RESET_PC;
      prev_stall = 1'b0;
      prev_addr  = '0;
      return;
    end
    acc = imem_req_valid && imem_req_ready;
    pop = inst_valid && inst_ready && !redirect;
    stale = 0;
    foreach (pending[k]) if (pending[k].epoch != epoch) stale++;

    check("addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, avail > 0});
    if (redirect) check("req_valid_in_redirect", {31'd0, imem_req_valid}, 32'd0);
    if (imem_req_valid) begin
      check("req_addr", imem_req_addr, model_pc);
      check("credit", {31'd0, (avail + pending.size() < DEPTH) && (pending.size() < MAX_OUTST)}, 32'd1);
      check("req_while_stale", stale, 32'd0);
    end
    if (prev_stall && !redirect) begin
      check("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_addr", imem_req_addr, prev_addr);
    end
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'd1, 32'd0);
      end else begin
        check("inst_pc", inst_pc, exp_q[0]);
        check("inst", inst, word(exp_q[0]));
        void'(exp_q.pop_front());
      end
      consumed.push_back(inst_pc);
      consumed_cyc.push_back(cyc);
      avail--;
    end

    if (imem_rsp_valid) begin
      if (pending.size() == 0) begin
        check("rsp_model", 32'd1, 32'd0);
      end else begin
        if (pending[0].epoch == epoch && !redirect) avail++;
        else dropped++;
        void'(pending.pop_front());
      end
    end
    if (acc) begin
      pending.push_back('{addr: imem_req_addr, due: cyc + lat, epoch: epoch});
      exp_q.push_back(imem_req_addr);
      accepted.push_back(imem_req_addr);
      model_pc = model_pc + 32'd4;
    end
    if (redirect) begin
      model_pc = redirect_pc & 32'hFFFF_FFFC;
      epoch++;
      exp_q.delete();
      avail = 0;
    end
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr  = imem_req_addr;
  endtask

  // ---------------- memory driver ----------------
  task automatic drive_mem();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b0;
    if (rst) begin
      if (!hold && pending.size() > 0 && pending[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(pending[0].addr);
      end
      imem_req_ready = (accepted.size() < acc_limit) && (ready_mode == 0 || cyc[0]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    hold       = 1'b0;
    acc_limit  = 1000;
    ready_mode = 0;
    repeat (3) tick();
    rst = 1'b1;
    accepted.delete();
    consumed.delete();
    consumed_cyc.delete();
    dropped = 0;
    rel_cyc = cyc;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    for (int i = 0; i < budget && accepted.size() < n; i++) tick();
    check(name, {31'd0, accepted.size() >= n}, 32'd1);
  endtask

  task automatic wait_con(input int n, input int budget, input string name);
    for (int i = 0; i < budget && consumed.size() < n; i++) tick();
    check(name, {31'd0, consumed.size() >= n}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    epoch = 0;
    // Reset values while rst is held low from time zero.
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // Streaming: one-cycle memory, decode always ready.
    lat = 1;
    do_reset();
    inst_ready = 1'b1;
    wait_con(4, 30, "t1_timeout");
    for (int i = 0; i < 4; i++) check("t1_pc_seq", con_at(i), 32'(4 * i));
    if (consumed_cyc.size() >= 4) begin
      check("t1_first_latency", 32'(consumed_cyc[0] - rel_cyc), 32'd3);
      for (int i = 1; i < 4; i++)
        check("t1_back_to_back", 32'(consumed_cyc[i] - consumed_cyc[0]), 32'(i));
    end
    repeat (10) tick();

    // Decode stalled: the credit rule must stop at exactly DEPTH requests.
    lat = 1;
    do_reset();
    repeat (20) tick();
    check("t2_req_count", accepted.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_req_addr", acc_at(i), 32'(4 * i));
    check("t2_req_valid_off", {31'd0, imem_req_valid}, 32'd0);
    inst_ready = 1'b1;
    wait_con(4, 10, "t2_timeout");
    for (int i = 0; i < 4; i++) check("t2_queue_pc", con_at(i), 32'(4 * i));

    // Redirect with three requests in flight; all three must be dropped.
    lat = 3;
    do_reset();
    hold       = 1'b1;
    acc_limit  = 3;
    inst_ready = 1'b1;
    wait_acc(3, 20, "t3_acc_timeout");
    check("t3_outstanding", pending.size(), 32'd3);
    pulse_redirect(32'h0000_0103);
    hold      = 1'b0;
    acc_limit = 1000;
    wait_con(1, 40, "t3_timeout");
    check("t3_dropped", dropped, 32'd3);
    check("t3_next_req", acc_at(3), 32'h0000_0100);
    check("t3_next_pc", con_at(0), 32'h0000_0100);
    repeat (10) tick();

    // Request channel toggling ready, random decode stalls.
    lat = 2;
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 80; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    inst_ready = 1'b1;
    repeat (12) tick();
    check("t4_progress", {31'd0, consumed.size() >= 8}, 32'd1);
    for (int i = 0; i < 8; i++) check("t4_order", con_at(i), 32'(4 * i));

    // Address wrap at the top of the address space.
    lat = 1;
    do_reset();
    acc_limit  = 0;
    inst_ready = 1'b1;
    repeat (3) tick();
    pulse_redirect(32'hFFFF_FFF8);
    acc_limit = 1000;
    wait_acc(3, 10, "t5_timeout");
    check("t5_addr0", acc_at(0), 32'hFFFF_FFF8);
    check("t5_addr1", acc_at(1), 32'hFFFF_FFFC);
    check("t5_addr2", acc_at(2), 32'h0000_0000);
    repeat (8) tick();

    // Asynchronous reset in the middle of a flush.
    lat = 2;
    do_reset();
    hold       = 1'b1;
    acc_limit  = 2;
    inst_ready = 1'b1;
    wait_acc(2, 20, "t6_acc_timeout");
    pulse_redirect(32'h0000_0040);
    #1;
    rst = 1'b0;
    #1;
    check("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_req_addr", imem_req_addr, RESET_PC);
    check("t6_inst", inst, 32'd0);
    check("t6_inst_pc", inst_pc, 32'd0);
    repeat (2) tick();
    hold      = 1'b0;
    acc_limit = 1000;
    rst       = 1'b1;
    accepted.delete();
    consumed.delete();
    wait_acc(1, 10, "t6_timeout");
    check("t6_first_req", acc_at(0), RESET_PC);
    wait_con(2, 20, "t6_con_timeout");
    check("t6_first_pc", con_at(0), RESET_PC);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
